branch_predict_unit: RTL

- Second-generation branch unit: resolves RV32I conditional branches and JAL/JALR in a registered stage, and adds a direct-mapped branch history table (BHT) of 2-bit saturating counters for fetch-side prediction.
- Sits between decode/execute (resolution) and fetch (prediction lookup).
- Outputs a registered taken flag, a mispredict flag and performance counters to the hazard/PC logic.

---
 rtl/branch_predict_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Registered RV32I branch/jump resolution with a direct-mapped BHT of 2-bit
// saturating counters for fetch-side prediction and saturating perf counters.
module branch_predict_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
  output logic                  predict_taken_o,
  input  logic                  resolve_valid_i,
  input  logic [ADDR_WIDTH-1:0] resolve_pc_i,
  input  logic [2:0]            branch_op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  predicted_taken_i,
  output logic                  take_o,
  output logic                  mispredict_o,
  output logic                  result_valid_o,
  output logic [CNT_WIDTH-1:0]  branch_count_o,
  output logic [CNT_WIDTH-1:0]  mispredict_count_o
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [2:0] {
    OP_BEQ  = 3'b000,
    OP_BNE  = 3'b001,
    OP_JUMP = 3'b010,
    OP_NONE = 3'b011,
    OP_BLT  = 3'b100,
    OP_BGE  = 3'b101,
    OP_BLTU = 3'b110,
    OP_BGEU = 3'b111
  } branch_op_e;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] resolve_idx;
  logic             take;
  logic             is_cond;
  logic             mispredict;
  logic             accept;
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_next;
  logic             unused_pc_bits;

  assign lookup_idx  = lookup_pc_i[IDX_W+1:2];
  assign resolve_idx = resolve_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{lookup_pc_i[ADDR_WIDTH-1:IDX_W+2], lookup_pc_i[1:0],
                            resolve_pc_i[ADDR_WIDTH-1:IDX_W+2], resolve_pc_i[1:0]};

  // No bypass: a same-cycle update to the looked-up entry shows next cycle.
  assign predict_taken_o = bht[lookup_idx][1];

  always_comb begin
    take    = 1'b0;
    is_cond = 1'b1;
    case (branch_op_e'(branch_op_i))
      OP_BEQ:  take = (a_i == b_i);
      OP_BNE:  take = (a_i != b_i);
      OP_BLT:  take = ($signed(a_i) <  $signed(b_i));
      OP_BGE:  take = ($signed(a_i) >= $signed(b_i));
      OP_BLTU: take = (a_i <  b_i);
      OP_BGEU: take = (a_i >= b_i);
      OP_JUMP: begin
        take    = 1'b1;
        is_cond = 1'b0;
      end
      default: begin
        take    = 1'b0;
        is_cond = 1'b0;
      end
    endcase
  end

  assign accept     = resolve_valid_i && !flush_i;
  assign mispredict = (branch_op_i == OP_NONE) ? 1'b0 : (take ^ predicted_taken_i);

  always_comb begin
    cnt_cur  = bht[resolve_idx];
    cnt_next = cnt_cur;
    if (take) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (accept && is_cond) begin
      bht[resolve_idx] <= cnt_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      take_o             <= 1'b0;
      mispredict_o       <= 1'b0;
      result_valid_o     <= 1'b0;
      branch_count_o     <= '0;
      mispredict_count_o <= '0;
    end else begin
      take_o         <= accept && take;
      mispredict_o   <= accept && mispredict;
      result_valid_o <= accept;
      if (accept && is_cond && (branch_count_o != '1))
        branch_count_o <= branch_count_o + CNT_WIDTH'(1);
      if (accept && mispredict && (mispredict_count_o != '1))
        mispredict_count_o <= mispredict_count_o + CNT_WIDTH'(1);
    end
  end

endmodule
